// File: rtl/stepper_sequencer_pkg.sv
// Shared constants, FSM encoding and phase-rotation helper for the MCC
// coil-decoder front end.
package mcc_pkg;

  localparam logic [2:0] CS_OFF = 3'd0;
  localparam logic [2:0] PH1    = 3'd1;
  localparam logic [2:0] PH2    = 3'd2;
  localparam logic [2:0] PH3    = 3'd3;
  localparam logic [2:0] PH4    = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DWELL = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Any out-of-range code recovers to PH1 so CS can never leave 0..4.
  function automatic logic [2:0] next_phase(input logic [2:0] phase, input logic dir);
    logic [2:0] nxt;
    nxt = PH1;
    if (phase >= PH1 && phase <= PH4) begin
      if (dir) nxt = (phase == PH4) ? PH1 : phase + 3'd1;
      else     nxt = (phase == PH1) ? PH4 : phase - 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/stepper_sequencer_if.sv
// Move-command / coil-state bundle between the command source and the
// stepper sequencer.
interface stepper_sequencer_if #(
  parameter int STEPS_W  = 16,
  parameter int PERIOD_W = 20
);
  logic                start;
  logic [STEPS_W-1:0]  steps;
  logic                dir;
  logic [PERIOD_W-1:0] period;
  logic                hold_en;
  logic                abort;
  logic [2:0]          CS;
  logic                busy;
  logic                done;

  modport master (
    output start, steps, dir, period, hold_en, abort,
    input  CS, busy, done
  );

  modport slave (
    input  start, steps, dir, period, hold_en, abort,
    output CS, busy, done
  );
endinterface

// File: rtl/stepper_sequencer_step_timer.sv
// Per-step tick generator: counts 0..P-1 while enabled, pulses tick_o on the
// last count and wraps to 0 in the same edge.
module step_timer #(
  parameter int PERIOD_W = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                tick_o
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;

  // period_i is never 0 here; the top clamps it to 1 when latching.
  assign tick_o = en_i && !clr_i && (cnt_q == period_i - PERIOD_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (en_i)   cnt_d = tick_o ? '0 : cnt_q + PERIOD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/stepper_sequencer.sv
// Turns move commands into the 3-bit coil current-state code, owning step
// timing, phase memory across moves, end-of-move dwell/hold and abort.
module stepper_sequencer
  import mcc_pkg::*;
#(
  parameter int STEPS_W  = 16,
  parameter int PERIOD_W = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  stepper_sequencer_if.slave  bus
);

  state_e              state_q;
  logic [2:0]          phase_q;
  logic [2:0]          cs_q;
  logic                busy_q;
  logic                done_q;
  logic [STEPS_W-1:0]  remain_q;
  logic                dir_q;
  logic [PERIOD_W-1:0] period_q;

  logic                timer_en, timer_clr, tick;
  logic                start_ok;
  logic [PERIOD_W-1:0] period_eff;
  logic [2:0]          phase_adv;

  assign timer_en   = (state_q == RUN) || (state_q == DWELL);
  assign timer_clr  = bus.abort || !timer_en;
  assign start_ok   = bus.start && ((state_q == IDLE) || (state_q == HOLD));
  assign period_eff = (bus.period == '0) ? PERIOD_W'(1) : bus.period;
  assign phase_adv  = next_phase(phase_q, dir_q);

  step_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (timer_clr),
    .en_i     (timer_en),
    .period_i (period_q),
    .tick_o   (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      phase_q  <= PH1;
      cs_q     <= CS_OFF;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      remain_q <= '0;
      dir_q    <= 1'b0;
      period_q <= PERIOD_W'(1);
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        // phase_q is deliberately kept so the next move starts where the rotor is.
        state_q  <= IDLE;
        cs_q     <= CS_OFF;
        busy_q   <= 1'b0;
        remain_q <= '0;
      end else begin
        case (state_q)
          IDLE, HOLD: begin
            if (start_ok) begin
              if (bus.steps == '0) begin
                done_q <= 1'b1;
              end else begin
                remain_q <= bus.steps;
                dir_q    <= bus.dir;
                period_q <= period_eff;
                state_q  <= RUN;
                cs_q     <= phase_q;
                busy_q   <= 1'b1;
              end
            end else if (state_q == HOLD && !bus.hold_en) begin
              state_q <= IDLE;
              cs_q    <= CS_OFF;
            end
          end
          RUN: begin
            if (tick) begin
              phase_q  <= phase_adv;
              cs_q     <= phase_adv;
              remain_q <= remain_q - STEPS_W'(1);
              if (remain_q == STEPS_W'(1)) state_q <= DWELL;
            end
          end
          DWELL: begin
            if (tick) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              if (bus.hold_en) begin
                state_q <= HOLD;
              end else begin
                state_q <= IDLE;
                cs_q    <= CS_OFF;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            cs_q    <= CS_OFF;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.CS   = cs_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_stepper_sequencer.sv
// Scoreboard bench for stepper_sequencer: each scenario queues the expected
// per-cycle (CS, busy, done) trace, then compares it cycle by cycle.
module tb_stepper_sequencer;

  logic clk;
  logic rst_n;

  stepper_sequencer_if #(.STEPS_W(16), .PERIOD_W(20)) bus ();

  stepper_sequencer #(.STEPS_W(16), .PERIOD_W(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] cs;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   ph     = 1;

  function automatic int adv(input int p, input bit d);
    if (d) return (p == 4) ? 1 : p + 1;
    else   return (p == 1) ? 4 : p - 1;
  endfunction

  task automatic push(input int c, input logic b, input logic d);
    exp_t e;
    e.cs = 3'(c); e.busy = b; e.done = d;
    sbq.push_back(e);
  endtask

  // Whole-move trace: N+1 phases of P cycles each, then the done cycle.
  task automatic push_move(input int n, input bit d, input int p, input bit hold);
    int pp;
    pp = (p == 0) ? 1 : p;
    for (int k = 0; k <= n; k++) begin
      repeat (pp) push(ph, 1'b1, 1'b0);
      if (k < n) ph = adv(ph, d);
    end
    push(hold ? ph : 0, 1'b0, 1'b1);
  endtask

  task automatic kick(input int s, input bit d, input int p);
    bus.steps  = 16'(s);
    bus.dir    = d;
    bus.period = 20'(p);
    bus.start  = 1'b1;
  endtask

  task automatic run_queue(input string name, input int start_at, input int abort_at);
    exp_t e;
    int   i;
    i = 0;
    while (sbq.size() > 0) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      e = sbq.pop_front();
      i++;
      n_chk++;
      if (bus.CS !== e.cs || bus.busy !== e.busy || bus.done !== e.done) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got CS=%0d busy=%b done=%b, expected CS=%0d busy=%b done=%b",
                 name, i, bus.CS, bus.busy, bus.done, e.cs, e.busy, e.done);
      end
      if (i == start_at) kick(7, 1'b1, 2);
      if (i == abort_at) bus.abort = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.hold_en = 1'b0;
    bus.steps = '0; bus.dir = 1'b0; bus.period = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus.CS !== 3'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got CS=%0d busy=%b done=%b, expected 0/0/0", bus.CS, bus.busy, bus.done);
    end
    rst_n = 1'b1;
    push(0, 1'b0, 1'b0);
    run_queue("reset_release", -1, -1);
    kick(0, 1'b1, 3);
    push(0, 1'b0, 1'b1);
    push(0, 1'b0, 1'b0);
    push(0, 1'b0, 1'b0);
    run_queue("zero_steps", -1, -1);
  endtask

  task automatic test_forward();
    bus.hold_en = 1'b0;
    kick(4, 1'b1, 3);
    push_move(4, 1'b1, 3, 1'b0);
    push(0, 1'b0, 1'b0);
    push(0, 1'b0, 1'b0);
    run_queue("forward", -1, -1);
  endtask

  task automatic test_reverse_hold();
    bus.hold_en = 1'b1;
    kick(2, 1'b0, 1);
    push_move(2, 1'b0, 1, 1'b1);
    push(ph, 1'b0, 1'b0);
    push(ph, 1'b0, 1'b0);
    run_queue("reverse_hold", -1, -1);
    bus.hold_en = 1'b0;
    push(0, 1'b0, 1'b0);
    push(0, 1'b0, 1'b0);
    run_queue("hold_release", -1, -1);
  endtask

  task automatic test_ignore_start();
    bus.hold_en = 1'b0;
    kick(3, 1'b1, 2);
    push_move(3, 1'b1, 2, 1'b0);
    push(0, 1'b0, 1'b0);
    push(0, 1'b0, 1'b0);
    run_queue("start_in_run", 3, -1);
  endtask

  task automatic test_abort();
    bus.hold_en = 1'b0;
    kick(10, 1'b1, 2);
    push(ph, 1'b1, 1'b0); push(ph, 1'b1, 1'b0);
    ph = adv(ph, 1'b1);
    push(ph, 1'b1, 1'b0); push(ph, 1'b1, 1'b0);
    ph = adv(ph, 1'b1);
    push(ph, 1'b1, 1'b0);
    repeat (5) push(0, 1'b0, 1'b0);
    run_queue("abort_run", -1, 5);
    kick(1, 1'b1, 2);
    push_move(1, 1'b1, 2, 1'b0);
    push(0, 1'b0, 1'b0);
    run_queue("after_abort", -1, -1);
  endtask

  task automatic test_abort_start_hold();
    bus.hold_en = 1'b1;
    kick(1, 1'b0, 1);
    push_move(1, 1'b0, 1, 1'b1);
    push(ph, 1'b0, 1'b0);
    run_queue("enter_hold", -1, -1);
    kick(3, 1'b1, 1);
    bus.abort = 1'b1;
    repeat (3) push(0, 1'b0, 1'b0);
    run_queue("abort_start_hold", -1, -1);
    bus.hold_en = 1'b0;
    kick(1, 1'b1, 1);
    push_move(1, 1'b1, 1, 1'b0);
    push(0, 1'b0, 1'b0);
    run_queue("phase_kept", -1, -1);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse_hold();
    test_ignore_start();
    test_abort();
    test_abort_start_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
